pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: count of un-acked fetch cycles before a fetch fault is raised; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 trap_req  in  1  trap/exception redirect request; highest priority.
REQ-005 branch_taken  in  1  branch/jump redirect request from execute.
REQ-006 stall  in  1  hazard-unit stall; holds fetch and PC.
REQ-007 imem_ack  in  1  instruction-memory acknowledge for the current imem_req.
REQ-008 imem_req  out  1  fetch request; level, held until imem_ack.
REQ-009 pc_src  out  2  PC next-value select: 00 sequential, 01 branch target, 10 trap vector; 11 never driven.
REQ-010 pc_en_n  out  1  active-low PC update enable.
REQ-011 flush  out  1  one-cycle pulse that kills younger in-flight instructions on redirect.
REQ-012 fetch_valid  out  1  one-cycle pulse: fetched instruction is valid for decode.
REQ-013 fetch_fault  out  1  level: fetch timed out; cleared only by trap_req.

Function
REQ-014 States SHALL be IDLE, FETCH, HOLD, DRAIN, FAULT, encoded in a 3-bit register.
REQ-015 pc_src, pc_en_n, flush and fetch_valid SHALL be combinational from state and inputs in the same cycle (Mealy); the PC samples them on the same edge.
REQ-016 Default outputs every cycle: pc_src=00, pc_en_n=1, flush=0, fetch_valid=0.
REQ-017 Redirect priority SHALL be trap_req > branch_taken > stall > sequential.
REQ-018 Redirect (any state except IDLE): pc_en_n=0, flush=1, pc_src=10 for trap_req, else 01 for branch_taken.
REQ-019 IDLE: imem_req=0; SHALL go to FETCH unconditionally on the first edge after reset release.
REQ-020 FETCH: imem_req=1. If imem_ack with no stall and no redirect, then fetch_valid=1, pc_en_n=0, pc_src=00; stay in FETCH.
REQ-021 FETCH, imem_ack with stall and no redirect: go to HOLD; pc_en_n=1, fetch_valid=0.
REQ-022 FETCH, redirect with imem_ack in the same cycle: discard the ack (fetch_valid=0); stay in FETCH.
REQ-023 FETCH, redirect without imem_ack: go to DRAIN.
REQ-024 HOLD: imem_req=0. When stall drops with no redirect, then fetch_valid=1, pc_en_n=0, pc_src=00, and go to FETCH. A redirect goes to FETCH and discards the held fetch.
REQ-025 DRAIN: imem_req=1. On imem_ack, discard (fetch_valid=0) and go to FETCH. A further redirect updates the PC per REQ-018 and stays in DRAIN, unless ack arrives in the same cycle, which goes to FETCH.
REQ-026 Wait counter (8-bit) SHALL increment each cycle in FETCH or DRAIN with imem_req=1 and imem_ack=0, and SHALL clear on imem_ack, on entry to FAULT, and on any redirect.
REQ-027 Counter reaching MEM_TIMEOUT-1 with no ack SHALL enter FAULT on the next edge; no wrap-around.
REQ-028 FAULT: imem_req=0, fetch_fault=1 (registered), pc_en_n=1. Only trap_req exits: apply the redirect, go to FETCH, and clear fetch_fault the next cycle. branch_taken and stall are ignored in FAULT.
REQ-029 Stall without imem_ack in FETCH: keep imem_req=1, pc_en_n=1, stay in FETCH.
REQ-030 pc_src=11 SHALL never be output; an illegal state encoding SHALL recover to IDLE.

Reset
REQ-031 reset_n low SHALL immediately force state=IDLE, counter=0, imem_req=0, fetch_fault=0, pc_en_n=1, pc_src=00, flush=0, fetch_valid=0, independent of clk.
REQ-032 Reset asserted mid-fetch, mid-drain or in FAULT SHALL abandon all pending work; no fetch_valid pulses until a new ack is received after reset release.

Verification
REQ-033 Reset release, imem_ack every cycle from cycle 2 -> IDLE for 1 cycle; then fetch_valid=1, pc_en_n=0, pc_src=00 every cycle.
REQ-034 trap_req and branch_taken together in FETCH without ack, ack 3 cycles later -> same cycle pc_src=10, flush=1, pc_en_n=0; DRAIN for 3 cycles; ack discarded (fetch_valid=0); back to FETCH.
REQ-035 Ack while stall=1, stall held 4 cycles -> HOLD with imem_req=0 and pc_en_n=1 for 4 cycles; on stall drop, one fetch_valid=1 with pc_src=00; back to FETCH.
REQ-036 MEM_TIMEOUT=4, imem_ack never asserted -> FAULT after 4 wait cycles, imem_req=0, fetch_fault=1; branch_taken ignored; trap_req -> pc_src=10, flush=1, FETCH, fetch_fault=0 next cycle.
REQ-037 reset_n pulsed low between clock edges while in DRAIN -> outputs reach reset values before the next edge; no discarded ack is later reported valid.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch/PC control FSM for a simple in-order core.
//
// Decides each cycle how the PC advances (sequential, branch target, trap
// vector), drives the instruction-memory request, and reports when a fetched
// instruction is valid for decode or when a fetch has timed out.
//
// Ports
//   clk           in   single clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   trap_req      in   trap/exception redirect (highest priority)
//   branch_taken  in   branch/jump redirect from execute
//   stall         in   hazard stall; holds fetch and PC
//   imem_ack      in   instruction-memory acknowledge
//   imem_req      out  fetch request (level)
//   pc_src        out  PC select: 00 sequential, 01 branch, 10 trap
//   pc_en_n       out  active-low PC update enable
//   flush         out  one-cycle kill of younger in-flight instructions
//   fetch_valid   out  one-cycle pulse: fetched instruction valid
//   fetch_fault   out  fetch timed out; cleared only by a trap
//   state_dbg     out  current FSM state (0 IDLE, 1 FETCH, 2 HOLD, 3 DRAIN, 4 FAULT)
//
// Memory handshake: imem_req is a level that stays high while the sequencer
// waits in FETCH or DRAIN; a transfer completes on any rising edge where
// imem_req and imem_ack are both high. An ack is only consumed as a valid
// instruction when no redirect or stall coincides with it; otherwise it is
// discarded (redirect) or parked in HOLD (stall) until the stall drops.
//
// pc_src, pc_en_n, flush and fetch_valid are combinational (Mealy) so the PC
// register can act on them at the same edge. imem_req decodes the state
// register directly; fetch_fault is a register.
module pc_sequencer #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trap_req,
  input  logic       branch_taken,
  input  logic       stall,
  input  logic       imem_ack,
  output logic       imem_req,
  output logic [1:0] pc_src,
  output logic       pc_en_n,
  output logic       flush,
  output logic       fetch_valid,
  output logic       fetch_fault,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       fault_next;
  logic       redirect;
  logic [1:0] redirect_src;
  logic       timeout;

  assign redirect     = trap_req | branch_taken;
  assign redirect_src = trap_req ? 2'b10 : 2'b01;
  // Last permitted wait cycle: a further missing ack moves to FAULT, so the
  // counter never needs to wrap.
  assign timeout      = (wait_cnt == (MEM_TIMEOUT - 8'd1));

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign state_dbg = state;

  always_comb begin
    pc_src        = 2'b00;
    pc_en_n       = 1'b1;
    flush         = 1'b0;
    fetch_valid   = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    fault_next    = fetch_fault;

    case (state)
      IDLE: begin
        state_next    = FETCH;
        wait_cnt_next = 8'd0;
      end

      FETCH: begin
        if (redirect) begin
          pc_src        = redirect_src;
          pc_en_n       = 1'b0;
          flush         = 1'b1;
          wait_cnt_next = 8'd0;
          // A coinciding ack belongs to the killed path and is dropped;
          // without one the old request is still outstanding and must drain.
          state_next    = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          wait_cnt_next = 8'd0;
          if (stall) begin
            state_next = HOLD;
          end else begin
            fetch_valid = 1'b1;
            pc_en_n     = 1'b0;
          end
        end else if (timeout) begin
          state_next    = FAULT;
          wait_cnt_next = 8'd0;
          fault_next    = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end

      HOLD: begin
        wait_cnt_next = 8'd0;
        if (redirect) begin
          pc_src     = redirect_src;
          pc_en_n    = 1'b0;
          flush      = 1'b1;
          state_next = FETCH;
        end else if (!stall) begin
          fetch_valid = 1'b1;
          pc_en_n     = 1'b0;
          state_next  = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          pc_src        = redirect_src;
          pc_en_n       = 1'b0;
          flush         = 1'b1;
          wait_cnt_next = 8'd0;
          if (imem_ack) state_next = FETCH;
        end else if (imem_ack) begin
          wait_cnt_next = 8'd0;
          state_next    = FETCH;
        end else if (timeout) begin
          state_next    = FAULT;
          wait_cnt_next = 8'd0;
          fault_next    = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end

      FAULT: begin
        wait_cnt_next = 8'd0;
        // Only a trap leaves FAULT; branch and stall are ignored here.
        if (trap_req) begin
          pc_src     = 2'b10;
          pc_en_n    = 1'b0;
          flush      = 1'b1;
          state_next = FETCH;
          fault_next = 1'b0;
        end
      end

      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
        fault_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      fetch_fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer (MEM_TIMEOUT = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// before the next rising edge. Each row of stimulus pushes its expected
// output vector {state, imem_req, pc_src, pc_en_n, flush, fetch_valid,
// fetch_fault} to exp_q, which is popped when the row is sampled.
module tb_pc_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  // {imem_req, pc_src, pc_en_n, flush, fetch_valid, fetch_fault}
  localparam logic [6:0] O_RST    = 7'b0_00_1_0_0_0;
  localparam logic [6:0] O_FV     = 7'b1_00_0_0_1_0;
  localparam logic [6:0] O_WAIT   = 7'b1_00_1_0_0_0;
  localparam logic [6:0] O_TRAP   = 7'b1_10_0_1_0_0;
  localparam logic [6:0] O_BR     = 7'b1_01_0_1_0_0;
  localparam logic [6:0] O_HOLD   = 7'b0_00_1_0_0_0;
  localparam logic [6:0] O_HREL   = 7'b0_00_0_0_1_0;
  localparam logic [6:0] O_HBR    = 7'b0_01_0_1_0_0;
  localparam logic [6:0] O_FLT    = 7'b0_00_1_0_0_1;
  localparam logic [6:0] O_FTRAP  = 7'b0_10_0_1_0_1;

  logic       clk;
  logic       reset_n;
  logic       trap_req;
  logic       branch_taken;
  logic       stall;
  logic       imem_ack;
  logic       imem_req;
  logic [1:0] pc_src;
  logic       pc_en_n;
  logic       flush;
  logic       fetch_valid;
  logic       fetch_fault;
  logic [2:0] state_dbg;

  logic [9:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  pc_sequencer #(.MEM_TIMEOUT(8'd4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trap_req     (trap_req),
    .branch_taken (branch_taken),
    .stall        (stall),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .pc_src       (pc_src),
    .pc_en_n      (pc_en_n),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_fault  (fetch_fault),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] ex(input logic [2:0] s, input logic [6:0] o);
    return {s, o};
  endfunction

  function automatic logic [9:0] sample();
    return {state_dbg, imem_req, pc_src, pc_en_n, flush, fetch_valid, fetch_fault};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] stim[$];
    logic [9:0] got, exp;
    int step = 0;
    // Reset held with every input active: outputs must stay at reset values.
    {trap_req, branch_taken, stall, imem_ack} = 4'b1111;
    exp_q.push_back(ex(S_IDLE, O_RST));
    #1;
    got = sample();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", got, exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // One IDLE cycle, then ack every cycle.
    stim.push_back(4'b0000); exp_q.push_back(ex(S_IDLE, O_RST));
    for (int i = 0; i < 4; i++) begin
      stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    end
    while (stim.size() > 0) begin
      {trap_req, branch_taken, stall, imem_ack} = stim.pop_front();
      #1;
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release step %0d: got %b expected %b", step, got, exp);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] stim[$];
    logic [9:0] got, exp;
    int n = $urandom_range(8, 16);
    int misses = 0;
    int step = 0;
    for (int i = 0; i < n; i++) begin
      logic ack;
      ack = ($urandom_range(0, 1) == 1) || (misses == 2) || (i == n - 1);
      misses = ack ? 0 : misses + 1;
      stim.push_back({3'b000, ack});
      exp_q.push_back(ack ? ex(S_FETCH, O_FV) : ex(S_FETCH, O_WAIT));
    end
    while (stim.size() > 0) begin
      {trap_req, branch_taken, stall, imem_ack} = stim.pop_front();
      #1;
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", step, got, exp);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [3:0] stim[$];
    logic [9:0] got, exp;
    int step = 0;
    stim.push_back(4'b1100); exp_q.push_back(ex(S_FETCH, O_TRAP));  // trap beats branch
    stim.push_back(4'b0000); exp_q.push_back(ex(S_DRAIN, O_WAIT));
    stim.push_back(4'b0000); exp_q.push_back(ex(S_DRAIN, O_WAIT));
    stim.push_back(4'b0001); exp_q.push_back(ex(S_DRAIN, O_WAIT));  // ack discarded
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    stim.push_back(4'b0101); exp_q.push_back(ex(S_FETCH, O_BR));    // redirect + ack
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    stim.push_back(4'b0100); exp_q.push_back(ex(S_FETCH, O_BR));
    stim.push_back(4'b1000); exp_q.push_back(ex(S_DRAIN, O_TRAP));  // redirect in drain
    stim.push_back(4'b0110); exp_q.push_back(ex(S_DRAIN, O_BR));    // branch beats stall
    stim.push_back(4'b1101); exp_q.push_back(ex(S_DRAIN, O_TRAP));  // redirect + ack leaves
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    while (stim.size() > 0) begin
      {trap_req, branch_taken, stall, imem_ack} = stim.pop_front();
      #1;
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL redirect step %0d: got %b expected %b", step, got, exp);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [3:0] stim[$];
    logic [9:0] got, exp;
    int step = 0;
    stim.push_back(4'b0011); exp_q.push_back(ex(S_FETCH, O_WAIT));  // ack under stall
    for (int i = 0; i < 4; i++) begin
      stim.push_back(4'b0010); exp_q.push_back(ex(S_HOLD, O_HOLD));
    end
    stim.push_back(4'b0000); exp_q.push_back(ex(S_HOLD, O_HREL));
    stim.push_back(4'b0010); exp_q.push_back(ex(S_FETCH, O_WAIT));  // stall, no ack
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    stim.push_back(4'b0011); exp_q.push_back(ex(S_FETCH, O_WAIT));
    stim.push_back(4'b0110); exp_q.push_back(ex(S_HOLD, O_HBR));    // held fetch dropped
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    while (stim.size() > 0) begin
      {trap_req, branch_taken, stall, imem_ack} = stim.pop_front();
      #1;
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stall step %0d: got %b expected %b", step, got, exp);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] stim[$];
    logic [9:0] got, exp;
    int step = 0;
    // Three misses then an ack: one short of the limit, no fault.
    for (int i = 0; i < 3; i++) begin
      stim.push_back(4'b0000); exp_q.push_back(ex(S_FETCH, O_WAIT));
    end
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    // Four misses (one with stall) reach FAULT.
    stim.push_back(4'b0000); exp_q.push_back(ex(S_FETCH, O_WAIT));
    stim.push_back(4'b0010); exp_q.push_back(ex(S_FETCH, O_WAIT));
    stim.push_back(4'b0000); exp_q.push_back(ex(S_FETCH, O_WAIT));
    stim.push_back(4'b0000); exp_q.push_back(ex(S_FETCH, O_WAIT));
    stim.push_back(4'b0110); exp_q.push_back(ex(S_FAULT, O_FLT));   // branch ignored
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FAULT, O_FLT));   // ack ignored
    stim.push_back(4'b1000); exp_q.push_back(ex(S_FAULT, O_FTRAP));
    stim.push_back(4'b0000); exp_q.push_back(ex(S_FETCH, O_WAIT));  // fault cleared
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    // Timeout while draining.
    stim.push_back(4'b0100); exp_q.push_back(ex(S_FETCH, O_BR));
    for (int i = 0; i < 4; i++) begin
      stim.push_back(4'b0000); exp_q.push_back(ex(S_DRAIN, O_WAIT));
    end
    stim.push_back(4'b1000); exp_q.push_back(ex(S_FAULT, O_FTRAP));
    stim.push_back(4'b0001); exp_q.push_back(ex(S_FETCH, O_FV));
    while (stim.size() > 0) begin
      {trap_req, branch_taken, stall, imem_ack} = stim.pop_front();
      #1;
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL timeout step %0d: got %b expected %b", step, got, exp);
      end
      step++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got, exp;
    // Enter DRAIN.
    {trap_req, branch_taken, stall, imem_ack} = 4'b0100;
    exp_q.push_back(ex(S_FETCH, O_BR));
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_enter_drain: got %b expected %b", got, exp); end
    @(negedge clk);
    // In DRAIN with a pending ack, pulse reset between edges.
    {trap_req, branch_taken, stall, imem_ack} = 4'b0001;
    exp_q.push_back(ex(S_DRAIN, O_WAIT));
    exp_q.push_back(ex(S_IDLE, O_RST));
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_drain: got %b expected %b", got, exp); end
    #1 reset_n = 1'b0;
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_drain_reset: got %b expected %b", got, exp); end
    #1 reset_n = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    // IDLE -> FETCH; the ack seen before reset must not surface.
    exp_q.push_back(ex(S_FETCH, O_WAIT));
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_after_reset: got %b expected %b", got, exp); end
    @(negedge clk);
    imem_ack = 1'b1;
    exp_q.push_back(ex(S_FETCH, O_FV));
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_new_ack: got %b expected %b", got, exp); end
    @(negedge clk);
    // Reach FAULT, then reset clears fetch_fault immediately.
    imem_ack = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(ex(S_FAULT, O_FLT));
    exp_q.push_back(ex(S_IDLE, O_RST));
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_fault: got %b expected %b", got, exp); end
    #1 reset_n = 1'b0;
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_fault_reset: got %b expected %b", got, exp); end
    #1 reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(ex(S_FETCH, O_WAIT));
    #1;
    got = sample(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_fault_recover: got %b expected %b", got, exp); end
    @(negedge clk);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_n = 1'b0;
    {trap_req, branch_taken, stall, imem_ack} = 4'b0000;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_redirect();
    test_stall();
    test_timeout();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
